// File: rtl/comb_bank_scheduler_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | comb_pkg : shared types, FSM encoding and arithmetic helpers for   |
// |            the comb bank scheduler.            Revision: 1.0       |
// +-------------------------------------------------------------------+
package comb_pkg;

  localparam int SAMPLE_W = 32;
  localparam int MAX_NCH  = 8;
  localparam int LEN_W    = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WAIT = 3'd2,
    ST_WR   = 3'd3,
    ST_OUT  = 3'd4
  } comb_state_e;

  // 0.5*x + 0.875*d, each term truncated toward -inf, sum wraps at SAMPLE_W bits
  function automatic sample_t fb_875(input sample_t x, input sample_t d);
    return (x >>> 1) + (d >>> 1) + (d >>> 2) + (d >>> 3);
  endfunction

  // Sum of the first k channel lengths; lens packs channel i in field i
  function automatic int base_addr(input logic [MAX_NCH*LEN_W-1:0] lens, input int k);
    int s;
    s = 0;
    for (int i = 0; i < MAX_NCH; i++) begin
      if (i < k) s += int'(lens[i*LEN_W +: LEN_W]);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/comb_bank_scheduler_if.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | comb_bank_scheduler_if : sample in/out handshake of the comb bank. |
// |                                                Revision: 1.0       |
// +-------------------------------------------------------------------+
interface comb_bank_scheduler_if;
  import comb_pkg::*;

  logic    enable;
  logic    sample_valid;
  sample_t in;
  sample_t out;
  logic    out_valid;
  logic    busy;
  logic    overrun;

  modport master (output enable, sample_valid, in,
                  input  out, out_valid, busy, overrun);
  modport slave  (input  enable, sample_valid, in,
                  output out, out_valid, busy, overrun);
endinterface
`default_nettype wire

// File: rtl/comb_bank_scheduler_delay_ram.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | delay_ram : single-port synchronous-read RAM, read-first, no reset.|
// |                                                Revision: 1.0       |
// +-------------------------------------------------------------------+
module delay_ram #(
  parameter int DEPTH = 4096,
  parameter int W     = 32,
  parameter int AW    = 12
) (
  input  wire logic          clk,
  input  wire logic          we,
  input  wire logic [AW-1:0] addr,
  input  wire logic [W-1:0]  wdata,
  output logic      [W-1:0]  rdata
);

  logic [W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/comb_bank_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | comb_bank_scheduler : NCH feedback combs time-sharing one delay    |
// |   RAM; CH_LEN packs channel i length in bits [16i+:16]. Rev: 1.0  |
// +-------------------------------------------------------------------+
module comb_bank_scheduler
  import comb_pkg::*;
#(
  parameter int                         NCH    = 4,
  parameter int                         W      = SAMPLE_W,
  parameter int                         DEPTH  = 4096,
  parameter logic [MAX_NCH*LEN_W-1:0]   CH_LEN = 128'h0000_0000_0000_0000_02A5_0281_0251_022D
) (
  input wire logic              clk,
  input wire logic              rst_n,
  comb_bank_scheduler_if.slave  bus
);

  localparam int LG        = $clog2(NCH);
  localparam int AW        = $clog2(DEPTH);
  localparam int ACC_W     = W + LG;
  localparam int TOTAL_LEN = base_addr(CH_LEN, NCH);

  if (W != SAMPLE_W) begin : g_err_width
    $error("W must equal comb_pkg::SAMPLE_W");
  end
  if (NCH < 2 || NCH > MAX_NCH || (NCH & (NCH - 1)) != 0) begin : g_err_nch
    $error("NCH must be a power of two in 2..8");
  end
  if (TOTAL_LEN > DEPTH) begin : g_err_depth
    $error("sum of CH_LEN exceeds DEPTH");
  end

  logic [AW-1:0] w_base [NCH];
  logic [AW-1:0] w_last [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    if (int'(CH_LEN[g*LEN_W +: LEN_W]) < 2) begin : g_err_len
      $error("each CH_LEN must be >= 2");
    end
    assign w_base[g] = AW'(base_addr(CH_LEN, g));
    assign w_last[g] = AW'(int'(CH_LEN[g*LEN_W +: LEN_W]) - 1);
  end

  comb_state_e             r_state;
  logic [LG-1:0]           r_k;
  logic [AW-1:0]           r_ptr [NCH];
  logic [NCH-1:0]          r_primed;
  sample_t                 r_x;
  logic signed [ACC_W-1:0] r_acc;
  sample_t                 r_out;
  logic                    r_out_valid;
  logic                    r_overrun;

  logic [AW-1:0]           w_ram_addr;
  logic                    w_ram_we;
  logic [W-1:0]            w_ram_q;
  sample_t                 w_d;
  sample_t                 w_wdata;
  logic signed [ACC_W-1:0] w_acc_shift;

  assign w_ram_addr  = w_base[r_k] + r_ptr[r_k];
  // Gated by enable so an abort in WR leaves this slot untouched
  assign w_ram_we    = (r_state == ST_WR) && bus.enable;
  assign w_d         = r_primed[r_k] ? sample_t'(w_ram_q) : '0;
  assign w_wdata     = fb_875(r_x, w_d);
  assign w_acc_shift = r_acc >>> LG;

  delay_ram #(.DEPTH(DEPTH), .W(W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .addr  (w_ram_addr),
    .wdata (w_wdata),
    .rdata (w_ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_primed    <= '0;
      r_x         <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) r_ptr[i] <= '0;
    end else if (!bus.enable) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_primed    <= '0;
      r_overrun   <= 1'b0;
      r_out       <= bus.in;
      r_out_valid <= bus.sample_valid;
      for (int i = 0; i < NCH; i++) r_ptr[i] <= '0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.sample_valid && r_state != ST_IDLE) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (bus.sample_valid) begin
            r_x     <= bus.in;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= ST_RD;
          end
        end
        ST_RD:   r_state <= ST_WAIT;
        ST_WAIT: r_state <= ST_WR;
        ST_WR: begin
          r_acc <= r_acc + {{LG{w_d[W-1]}}, w_d};
          if (r_ptr[r_k] == w_last[r_k]) begin
            r_ptr[r_k]    <= '0;
            r_primed[r_k] <= 1'b1;
          end else begin
            r_ptr[r_k] <= r_ptr[r_k] + 1'b1;
          end
          if (r_k == LG'(NCH - 1)) begin
            r_state <= ST_OUT;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= ST_RD;
          end
        end
        ST_OUT: begin
          r_out       <= w_acc_shift[W-1:0];
          r_out_valid <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_comb_bank_scheduler.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_comb_bank_scheduler : directed bench, NCH=4, CH_LEN={3,5,7,11}. |
// |                                                Revision: 1.0       |
// +-------------------------------------------------------------------+
module tb_comb_bank_scheduler;
  import comb_pkg::*;

  localparam int NCH = 4;
  localparam int LENS  [NCH] = '{3, 5, 7, 11};
  localparam int BASES [NCH] = '{0, 3, 8, 15};
  localparam sample_t IMP = 32'h4000_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   wr_cnt;

  comb_bank_scheduler_if bus ();

  comb_bank_scheduler #(
    .NCH    (NCH),
    .W      (32),
    .DEPTH  (64),
    .CH_LEN (128'h0000_0000_0000_0000_000B_0007_0005_0003)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference comb bank, one ring per channel
  sample_t m_ring [NCH][11];
  int      m_ptr  [NCH];
  bit      m_pr   [NCH];

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_ptr[c] = 0;
      m_pr[c]  = 1'b0;
      for (int j = 0; j < 11; j++) m_ring[c][j] = '0;
    end
  endtask

  task automatic model_step(input sample_t x, output sample_t y);
    logic signed [33:0] acc;
    sample_t d;
    acc = '0;
    for (int c = 0; c < NCH; c++) begin
      d = m_pr[c] ? m_ring[c][m_ptr[c]] : '0;
      m_ring[c][m_ptr[c]] = (x >>> 1) + (d >>> 1) + (d >>> 2) + (d >>> 3);
      acc = acc + {{2{d[31]}}, d};
      if (m_ptr[c] == LENS[c] - 1) begin
        m_ptr[c] = 0;
        m_pr[c]  = 1'b1;
      end else begin
        m_ptr[c] = m_ptr[c] + 1;
      end
    end
    y = acc[33:2];
  endtask

  // One clock, then watch the RAM write window and X on out
  task automatic tick();
    int c;
    @(posedge clk);
    #1;
    if (rst_n) begin
      checks++;
      if ($isunknown(bus.out)) begin
        errors++;
        $display("FAIL out_x: out=%h required known", bus.out);
      end
      if (dut.w_ram_we) begin
        c = wr_cnt % NCH;
        checks++;
        if (int'(dut.w_ram_addr) < BASES[c] || int'(dut.w_ram_addr) > BASES[c] + LENS[c] - 1) begin
          errors++;
          $display("FAIL addr_window ch%0d: addr=%0d required %0d..%0d",
                   c, dut.w_ram_addr, BASES[c], BASES[c] + LENS[c] - 1);
        end
        wr_cnt++;
      end
    end
  endtask

  task automatic run_sample(input sample_t v, output sample_t got, output int lat);
    tick();
    bus.sample_valid = 1'b1;
    bus.in           = v;
    wr_cnt           = 0;
    tick();
    bus.sample_valid = 1'b0;
    bus.in           = '0;
    lat = 0;
    got = '0;
    for (int i = 1; i <= 30 && lat == 0; i++) begin
      tick();
      if (bus.out_valid) begin
        lat = i;
        got = bus.out;
      end
    end
    repeat (3) tick();
  endtask

  task automatic reinit();
    tick();
    bus.enable = 1'b0;
    tick();
    tick();
    bus.enable = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h ov=%b busy=%b overrun=%b required 0/0/0/0",
               bus.out, bus.out_valid, bus.busy, bus.overrun);
    end
    #19 rst_n = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b required 0", bus.busy);
    end
  endtask

  task automatic test_latency_priming();
    sample_t got, exp_m;
    int lat;
    sample_t exp_h [12];
    exp_h = '{32'h0, 32'h0, 32'h0, 32'h0800_0000, 32'h0, 32'h0800_0000,
              32'h0700_0000, 32'h0800_0000, 32'h0, 32'h0620_0000, 32'h0700_0000, 32'h0800_0000};
    reinit();
    for (int s = 0; s < 16; s++) begin
      run_sample((s == 0) ? IMP : '0, got, lat);
      model_step((s == 0) ? IMP : '0, exp_m);
      checks++;
      if (lat !== 13) begin
        errors++;
        $display("FAIL latency s%0d: got %0d cycles required 13", s, lat);
      end
      checks++;
      if (got !== exp_m) begin
        errors++;
        $display("FAIL impulse_model s%0d: out=%h required %h", s, got, exp_m);
      end
      if (s < 12) begin
        checks++;
        if (got !== exp_h[s]) begin
          errors++;
          $display("FAIL impulse_hand s%0d: out=%h required %h", s, got, exp_h[s]);
        end
      end
    end
  endtask

  task automatic test_overrun();
    sample_t got;
    int lat, pulses;
    reinit();
    tick();
    bus.sample_valid = 1'b1;
    bus.in           = IMP;
    wr_cnt           = 0;
    tick();
    bus.sample_valid = 1'b0;
    repeat (4) tick();
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.in           = '0;
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: overrun=%b required 1", bus.overrun);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.out_valid) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL overrun_pulses: got %0d out_valid pulses required 1", pulses);
    end
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b required 1", bus.overrun);
    end
    for (int s = 1; s <= 3; s++) begin
      run_sample('0, got, lat);
      checks++;
      if (got !== ((s == 3) ? sample_t'(32'h0800_0000) : sample_t'(32'h0))) begin
        errors++;
        $display("FAIL overrun_ptr s%0d: out=%h required %h", s, got,
                 (s == 3) ? 32'h0800_0000 : 32'h0);
      end
    end
  endtask

  task automatic test_reset_mid_pass();
    sample_t got;
    int lat;
    tick();
    bus.sample_valid = 1'b1;
    bus.in           = IMP;
    wr_cnt           = 0;
    tick();
    bus.sample_valid = 1'b0;
    bus.in           = '0;
    repeat (8) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: out=%h ov=%b busy=%b overrun=%b required 0/0/0/0",
               bus.out, bus.out_valid, bus.busy, bus.overrun);
    end
    #2 rst_n = 1'b1;
    model_reset();
    run_sample(IMP, got, lat);
    checks++;
    if (got !== '0 || lat !== 13) begin
      errors++;
      $display("FAIL post_reset_out: out=%h lat=%0d required 0 and 13", got, lat);
    end
  endtask

  task automatic test_bypass();
    sample_t got;
    int lat;
    tick();
    bus.sample_valid = 1'b1;
    bus.in           = IMP;
    wr_cnt           = 0;
    tick();
    bus.sample_valid = 1'b0;
    tick();
    tick();
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    checks++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL bypass_pre: overrun=%b busy=%b required 1/1", bus.overrun, bus.busy);
    end
    bus.enable       = 1'b0;
    bus.in           = 32'h1234_5678;
    bus.sample_valid = 1'b1;
    tick();
    checks++;
    if (bus.out !== 32'h1234_5678 || bus.out_valid !== 1'b1 || bus.overrun !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass: out=%h ov=%b overrun=%b busy=%b required 12345678/1/0/0",
               bus.out, bus.out_valid, bus.overrun, bus.busy);
    end
    bus.sample_valid = 1'b0;
    bus.in           = '0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out !== '0) begin
      errors++;
      $display("FAIL bypass_follow: out=%h ov=%b required 0/0", bus.out, bus.out_valid);
    end
    bus.enable = 1'b1;
    model_reset();
    for (int s = 0; s < 4; s++) begin
      run_sample((s == 0) ? IMP : '0, got, lat);
      checks++;
      if (got !== ((s == 3) ? sample_t'(32'h0800_0000) : sample_t'(32'h0))) begin
        errors++;
        $display("FAIL reenable s%0d: out=%h required %h", s, got,
                 (s == 3) ? 32'h0800_0000 : 32'h0);
      end
    end
  endtask

  task automatic test_wrap_full_scale();
    sample_t got, exp_m;
    int lat;
    reinit();
    for (int s = 0; s < 50; s++) begin
      run_sample(32'h7FFF_FFFF, got, lat);
      model_step(32'h7FFF_FFFF, exp_m);
      checks++;
      if (got !== exp_m || lat !== 13) begin
        errors++;
        $display("FAIL full_scale s%0d: out=%h lat=%0d required %h and 13", s, got, lat, exp_m);
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    wr_cnt           = 0;
    rst_n            = 1'b1;
    bus.enable       = 1'b1;
    bus.sample_valid = 1'b0;
    bus.in           = '0;
    model_reset();
    #2 rst_n = 1'b0;
    test_reset();
    test_latency_priming();
    test_overrun();
    test_reset_mid_pass();
    test_bypass();
    test_wrap_full_scale();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
